// File: rtl/q_chain_loader.sv
// q_chain_loader: serial load / clear / preset controller for a chain of Q_FRAG cells.
// Ports: QCK clock, QRT async active-high reset; IN_VALID/IN_READY/IN_CMD/IN_DATA command
// handshake (00 load, 01 clear, 10 preset, 11 reserved); QDI_O/QEN_O/QRT_O/QST_O/CDS_O
// registered chain controls; BUSY while not idle, DONE/ERR one-cycle completion pulses.
module q_chain_loader #(
    parameter int WIDTH      = 8,
    parameter int CLR_CYCLES = 2
) (
    input  logic             QCK,
    input  logic             QRT,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [1:0]       IN_CMD,
    input  logic [WIDTH-1:0] IN_DATA,
    output logic             QDI_O,
    output logic             QEN_O,
    output logic             QRT_O,
    output logic             QST_O,
    output logic             CDS_O,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);
    localparam int MAXC = WIDTH > CLR_CYCLES ? WIDTH : CLR_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    typedef enum logic [2:0] {IDLE, SHIFT, CLR, SET, FINISH} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             qdi_q, qdi_d;
    logic             qen_q, qen_d;
    logic             qrt_q, qrt_d;
    logic             qst_q, qst_d;
    logic             cds_q, cds_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             accept;
    assign IN_READY = (state_q == IDLE) && !QRT;
    assign accept   = IN_VALID && IN_READY;
    assign BUSY     = state_q != IDLE;
    assign QDI_O    = qdi_q;
    assign QEN_O    = qen_q;
    assign QRT_O    = qrt_q;
    assign QST_O    = qst_q;
    assign CDS_O    = cds_q;
    assign DONE     = done_q;
    assign ERR      = err_q;
    // Outputs are derived from the next state so every pin is a flop and changes only on QCK.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        qdi_d   = qdi_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (IN_CMD)
                        2'b00: begin
                            // First bit goes out immediately; the rest wait MSB-aligned in sr.
                            state_d = SHIFT;
                            cnt_d   = CW'(WIDTH);
                            qdi_d   = IN_DATA[WIDTH-1];
                            sr_d    = IN_DATA << 1;
                        end
                        2'b01: begin
                            state_d = CLR;
                            cnt_d   = CW'(CLR_CYCLES);
                        end
                        2'b10: begin
                            state_d = SET;
                            cnt_d   = CW'(CLR_CYCLES);
                        end
                        default: begin
                            state_d = FINISH;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            SHIFT, CLR, SET: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = FINISH;
                end else if (state_q == SHIFT) begin
                    qdi_d = sr_q[WIDTH-1];
                    sr_d  = sr_q << 1;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        qen_d  = state_d == SHIFT;
        qrt_d  = state_d == CLR;
        qst_d  = state_d == SET;
        cds_d  = (state_d != CLR) && (state_d != SET);
        done_d = state_d == FINISH;
    end
    always_ff @(posedge QCK or posedge QRT) begin
        if (QRT) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            qdi_q   <= 1'b0;
            qen_q   <= 1'b0;
            qrt_q   <= 1'b1;
            qst_q   <= 1'b0;
            cds_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            qdi_q   <= qdi_d;
            qen_q   <= qen_d;
            qrt_q   <= qrt_d;
            qst_q   <= qst_d;
            cds_q   <= cds_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: doc/q_chain_loader.md
Name: q_chain_loader

Overview:
- Upstream control stage for a chain of Q_FRAG flip-flops wired as a shift register (each QDI fed by the previous cell's AQZ).
- Accepts commands over a valid/ready interface: serial word load, chain clear or chain preset.
- Drives the chain's QDI, QEN, QRT, QST and CDS pins with registered, glitch-free outputs.
- Used by simulation benches and packed-design harnesses to initialise register chains deterministically.

Parameters:
- WIDTH, 8, number of cells in the chain and bits per load word; must be >= 1.
- CLR_CYCLES, 2, number of cycles QRT_O or QST_O is held high for a clear or preset command; must be >= 1.

Ports:
- QCK  input  1  clock; all state changes on its rising edge.
- QRT  input  1  reset, asynchronous, active-high.
- IN_VALID  input  1  command valid.
- IN_READY  output  1  command ready.
- IN_CMD  input  2  command: 00 load, 01 clear, 10 preset, 11 reserved.
- IN_DATA  input  WIDTH  load word; used only when IN_CMD=00.
- QDI_O  output  1  serial data to the first chain cell.
- QEN_O  output  1  chain clock enable.
- QRT_O  output  1  chain reset, to the cells' QRT pins.
- QST_O  output  1  chain set, to the cells' QST pins.
- CDS_O  output  1  chain data-select enable.
- BUSY  output  1  high whenever the block is not IDLE.
- DONE  output  1  one-cycle pulse when a command completes.
- ERR  output  1  one-cycle pulse together with DONE when the completed command was 11.

Behaviour:
- States: IDLE, SHIFT, CLR, SET, FINISH. A down-counter of width $clog2(max(WIDTH,CLR_CYCLES)+1) serves SHIFT, CLR and SET.
- Reset (QRT high, asynchronous):
  - State goes to IDLE and the counter and shift register clear.
  - QRT_O=1; QDI_O, QEN_O, QST_O, CDS_O, DONE and ERR are 0; BUSY=0; IN_READY=0.
- First QCK edge after QRT falls: QRT_O=0 and CDS_O=1.
- IN_READY = (state==IDLE) && !QRT. This is combinational, and IN_READY=1 in IDLE does not depend on IN_VALID.
- A command is accepted at a rising edge where IN_VALID && IN_READY. While not IDLE, IN_VALID is ignored; upstream holds its command.
- Load (00):
  - On acceptance, IN_DATA is latched and the block enters SHIFT with count=WIDTH.
  - For exactly WIDTH consecutive cycles starting the cycle after acceptance: QEN_O=1 and QDI_O carries IN_DATA MSB first (cycle k carries bit WIDTH-1-k).
  - After the final shift edge, cell 0 holds bit 0 and the last cell holds bit WIDTH-1.
- Clear (01): enter CLR. QRT_O=1, QEN_O=0 and CDS_O=0 for exactly CLR_CYCLES cycles.
- Preset (10): enter SET. QST_O=1, QEN_O=0 and CDS_O=0 for exactly CLR_CYCLES cycles.
- Reserved (11): go directly to FINISH with no chain activity.
- FINISH:
  - Lasts one cycle: DONE=1, ERR=1 only for command 11, then IDLE.
  - QEN_O, QRT_O and QST_O are 0, and CDS_O=1.
- Latency from acceptance to DONE: WIDTH+1 cycles for load, CLR_CYCLES+1 for clear/preset, 1 for reserved. The next command can be accepted the cycle after DONE.
- Invariants:
  - QRT_O and QST_O are never both 1.
  - QEN_O is never 1 while QRT_O or QST_O is 1.
  - QDI_O holds its last value when QEN_O=0.
- Reset asserted mid-command: the command is aborted immediately, no DONE is issued, and outputs take their reset values in the same instant.

Test Plan:
- Reset release, then load WIDTH=8 with IN_DATA=8'hA5 -> acceptance the first cycle IN_READY=1; QEN_O high for 8 cycles; QDI_O sequence 1,0,1,0,0,1,0,1; DONE the next cycle; the chain model reads 8'hA5; ERR=0.
- Clear with CLR_CYCLES=2 after the load -> QRT_O high for 2 cycles with CDS_O=0; DONE; every chain cell AQZ=0; QST_O stays 0.
- Preset then load 8'h00 back-to-back, IN_VALID held high -> second acceptance the cycle after the preset DONE; chain 8'hFF after preset, 8'h00 after load.
- Reserved command 11 -> DONE and ERR pulse one cycle after acceptance; QEN_O, QRT_O, QST_O stay 0; chain contents unchanged.
- QRT asserted at shift cycle 3 of a load -> outputs immediately at reset values (QRT_O=1, QEN_O=0); no DONE; after release a fresh load of 8'h3C completes correctly.
- IN_VALID toggled during BUSY with differing IN_DATA -> IN_READY=0 throughout; in-flight QDI_O bits match the originally latched word.
